// File: rtl/dp_bram_clr.sv
// True dual-port byte-write RAM with a whole-memory clear engine; q/rvalid arrive READ_LATENCY (1|2) cycles after ce.
// No backpressure: accesses are accepted every cycle except while clr_busy, when ce is ignored.
module dp_bram_clr #(
    parameter int ADDR_WIDTH   = 9,
    parameter int MEM_DEPTH    = 512,
    parameter int COL_WIDTH    = 8,
    parameter int NUM_COL      = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0,
    localparam int MEM_WIDTH   = COL_WIDTH * NUM_COL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  ce0,
    input  logic                  ce1,
    input  logic [NUM_COL-1:0]    we0,
    input  logic [NUM_COL-1:0]    we1,
    input  logic [MEM_WIDTH-1:0]  d0,
    input  logic [MEM_WIDTH-1:0]  d1,
    output logic [MEM_WIDTH-1:0]  q0,
    output logic [MEM_WIDTH-1:0]  q1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  collision
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_last;

    logic                  acc0, acc1, wr0, wr1, same;
    logic [MEM_WIDTH-1:0]  old0, old1, m0, m1, rd0, rd1;

    logic                  s1_vld0, s1_vld1, s2_vld0, s2_vld1;
    logic [MEM_WIDTH-1:0]  s1_dat0, s1_dat1, s2_dat0, s2_dat1;

    function automatic logic [MEM_WIDTH-1:0] merge(input logic [MEM_WIDTH-1:0] old,
                                                   input logic [MEM_WIDTH-1:0] nd,
                                                   input logic [NUM_COL-1:0]   we);
        logic [MEM_WIDTH-1:0] w;
        w = old;
        for (int i = 0; i < NUM_COL; i++)
            if (we[i]) w[i*COL_WIDTH +: COL_WIDTH] = nd[i*COL_WIDTH +: COL_WIDTH];
        return w;
    endfunction

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);
    assign clr_last = (clr_addr == ADDR_WIDTH'(MEM_DEPTH - 1));

    // Same-address accesses merge port 0 first, then port 1 on top, so port 1 wins overlapping columns.
    always_comb begin
        acc0 = ce0 & ~clr_busy;
        acc1 = ce1 & ~clr_busy;
        wr0  = acc0 & (|we0);
        wr1  = acc1 & (|we1);
        same = acc0 & acc1 & (addr0 == addr1);
        old0 = mem[addr0];
        old1 = mem[addr1];
        m0   = merge(old0, d0, acc0 ? we0 : '0);
        m1   = merge(same ? m0 : old1, d1, acc1 ? we1 : '0);
        rd0  = old0;
        rd1  = old1;
        if (WRITE_MODE == 1 && wr0) rd0 = same ? m1 : m0;
        if (WRITE_MODE == 1 && wr1) rd1 = m1;
    end

    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0 && !same)         mem[addr0] <= m0;
            if (wr1 || (same && wr0)) mem[addr1] <= m1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld0   <= 1'b0;
            s1_vld1   <= 1'b0;
            s2_vld0   <= 1'b0;
            s2_vld1   <= 1'b0;
            s1_dat0   <= '0;
            s1_dat1   <= '0;
            s2_dat0   <= '0;
            s2_dat1   <= '0;
            collision <= 1'b0;
        end else begin
            s1_vld0   <= acc0;
            s1_vld1   <= acc1;
            s2_vld0   <= s1_vld0;
            s2_vld1   <= s1_vld1;
            if (acc0)    s1_dat0 <= rd0;
            if (acc1)    s1_dat1 <= rd1;
            if (s1_vld0) s2_dat0 <= s1_dat0;
            if (s1_vld1) s2_dat1 <= s1_dat1;
            collision <= same & (wr0 | wr1);
        end
    end

    assign q0      = (READ_LATENCY == 2) ? s2_dat0 : s1_dat0;
    assign q1      = (READ_LATENCY == 2) ? s2_dat1 : s1_dat1;
    assign rvalid0 = (READ_LATENCY == 2) ? s2_vld0 : s1_vld0;
    assign rvalid1 = (READ_LATENCY == 2) ? s2_vld1 : s1_vld1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_start) state_d = CLEAR;
            CLEAR:   if (clr_last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      clr_addr <= '0;
        else if (clr_busy) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end

endmodule

// File: tb/tb_dp_bram_clr.sv
// Directed bench: instance a is READ_FIRST/latency 1, instance b is WRITE_FIRST/latency 2, both driven by the same stimulus.
module tb_dp_bram_clr;

    logic        clk, reset_n;
    logic [8:0]  addr0, addr1;
    logic        ce0, ce1, clr_start;
    logic [3:0]  we0, we1;
    logic [31:0] d0, d1;
    logic [31:0] a_q0, a_q1, b_q0, b_q1;
    logic        a_rv0, a_rv1, a_busy, a_done, a_coll;
    logic        b_rv0, b_rv1, b_busy, b_done, b_coll;

    int n_chk  = 0;
    int n_pass = 0;

    dp_bram_clr #(.READ_LATENCY(1), .WRITE_MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1),
        .we0(we0), .we1(we1), .d0(d0), .d1(d1), .q0(a_q0), .q1(a_q1),
        .rvalid0(a_rv0), .rvalid1(a_rv1), .clr_start(clr_start), .clr_busy(a_busy),
        .clr_done(a_done), .collision(a_coll));

    dp_bram_clr #(.READ_LATENCY(2), .WRITE_MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1),
        .we0(we0), .we1(we1), .d0(d0), .d1(d1), .q0(b_q0), .q1(b_q1),
        .rvalid0(b_rv0), .rvalid1(b_rv1), .clr_start(clr_start), .clr_busy(b_busy),
        .clr_done(b_done), .collision(b_coll));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce0 = 0; ce1 = 0; we0 = '0; we1 = '0; clr_start = 0;
    endtask

    task automatic acc(input logic c0, input logic [8:0] a0, input logic [3:0] w0, input logic [31:0] x0,
                       input logic c1, input logic [8:0] a1, input logic [3:0] w1, input logic [31:0] x1);
        ce0 = c0; addr0 = a0; we0 = w0; d0 = x0;
        ce1 = c1; addr1 = a1; we1 = w1; d1 = x1;
        tick();
        idle();
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 256; i++)
            acc(1, 9'(i), 4'hF, 32'hFFFFFFFF, 1, 9'(i + 256), 4'hF, 32'hFFFFFFFF);
    endtask

    function automatic logic [31:0] expv(input int a, input int z_hi);
        return (a < z_hi) ? 32'h0 : 32'hFFFFFFFF;
    endfunction

    // Reads every address on both ports; addresses below z_hi must be zero, the rest all ones.
    task automatic check_mem(input string tag, input int z_hi);
        int bad_a = 0;
        int bad_b = 0;
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                ce0 = 1; addr0 = 9'(i); ce1 = 1; addr1 = 9'(i + 256);
            end else idle();
            tick();
            if (i < 256) begin
                if (a_q0 !== expv(i, z_hi) || !a_rv0) bad_a++;
                if (a_q1 !== expv(i + 256, z_hi) || !a_rv1) bad_a++;
            end
            if (i >= 1) begin
                if (b_q0 !== expv(i - 1, z_hi) || !b_rv0) bad_b++;
                if (b_q1 !== expv(i + 255, z_hi) || !b_rv1) bad_b++;
            end
        end
        idle();
        chk({tag, "_a"}, bad_a, 0);
        chk({tag, "_b"}, bad_b, 0);
    endtask

    initial begin
        int busy_cnt;
        logic rv_seen, done_seen;
        reset_n = 0; addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
        idle();
        tick(); tick();
        chk("rst_q0", a_q0, 0);
        chk("rst_rv", {a_rv0, a_rv1, b_rv0, b_rv1}, 0);
        chk("rst_flags", {a_busy, a_done, a_coll, b_busy, b_done, b_coll}, 0);
        reset_n = 1;
        tick();

        // Column write then read; latency 1 vs 2.
        acc(1, 5, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0);
        acc(1, 5, 4'h2, 32'h00001100, 0, 0, 0, 0);
        tick();
        acc(1, 5, 4'h0, 32'h0, 0, 0, 0, 0);
        chk("bw_a_q0", a_q0, 32'hAABB11DD);
        chk("bw_a_rv0", a_rv0, 1);
        chk("bw_b_rv0_early", b_rv0, 0);
        tick();
        chk("bw_b_q0", b_q0, 32'hAABB11DD);
        chk("bw_b_rv0", b_rv0, 1);
        chk("bw_a_rv0_after", a_rv0, 0);

        // Read-first vs write-first.
        acc(1, 3, 4'hF, 32'h22222222, 0, 0, 0, 0);
        acc(1, 3, 4'hF, 32'h11111111, 0, 0, 0, 0);
        chk("rf_a_q0", a_q0, 32'h22222222);
        tick();
        chk("wf_b_q0", b_q0, 32'h11111111);
        acc(0, 0, 0, 0, 1, 4, 4'hF, 32'h33333333);
        acc(0, 0, 0, 0, 1, 4, 4'hF, 32'h44444444);
        chk("rf_a_q1", a_q1, 32'h33333333);
        tick();
        chk("wf_b_q1", b_q1, 32'h44444444);

        // Same-address collisions.
        acc(1, 7, 4'hF, 32'h0, 0, 0, 0, 0);
        acc(1, 7, 4'hF, 32'h01020304, 1, 7, 4'h3, 32'hA0B0C0D0);
        chk("col_a_flag", a_coll, 1);
        chk("col_b_flag", b_coll, 1);
        chk("col_a_q0", a_q0, 32'h0);
        chk("col_a_q1", a_q1, 32'h0);
        tick();
        chk("col_a_pulse", a_coll, 0);
        chk("col_b_q0", b_q0, 32'h0102C0D0);
        chk("col_b_q1", b_q1, 32'h0102C0D0);
        acc(1, 7, 4'h0, 32'h0, 1, 7, 4'hF, 32'h55555555);
        chk("colr_a_flag", a_coll, 1);
        chk("colr_a_q0", a_q0, 32'h0102C0D0);
        tick();
        chk("colr_b_q0", b_q0, 32'h0102C0D0);
        chk("colr_b_q1", b_q1, 32'h55555555);
        acc(1, 7, 4'h0, 32'h0, 1, 7, 4'h0, 32'h0);
        chk("rr_no_col", a_coll, 0);
        chk("rr_a_q0", a_q0, 32'h55555555);
        tick();

        // Full clear; start cycle carries a read, busy cycles carry ignored writes.
        fill_ones();
        clr_start = 1; ce0 = 1; addr0 = 9; we0 = 0;
        tick();
        idle();
        chk("clr_busy_start", a_busy, 1);
        chk("clr_start_rd_a", a_q0, 32'hFFFFFFFF);
        chk("clr_start_rv_a", a_rv0, 1);
        ce0 = 1; addr0 = 0; we0 = 4'hF; d0 = 32'hDEADBEEF;
        ce1 = 1; addr1 = 1; we1 = 4'hF; d1 = 32'hDEADBEEF;
        busy_cnt = 1;
        rv_seen = 0;
        tick();
        chk("clr_inflight_b", b_q0, 32'hFFFFFFFF);
        chk("clr_inflight_b_rv", b_rv0, 1);
        while (a_busy && busy_cnt < 2000) begin
            busy_cnt++;
            rv_seen |= a_rv0 | a_rv1;
            if (busy_cnt == 300) clr_start = 1;
            tick();
            clr_start = 0;
        end
        idle();
        chk("clr_busy_cycles", busy_cnt, 512);
        chk("clr_busy_rv", rv_seen, 0);
        chk("clr_done_hi", {a_done, a_busy, b_done}, 3'b101);
        tick();
        chk("clr_done_pulse", {a_done, b_done, a_busy}, 0);
        check_mem("clr_mem", 512);

        // Reset at clear address 100.
        fill_ones();
        clr_start = 1; ce0 = 1; addr0 = 9; we0 = 0;
        tick();
        idle();
        done_seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 50) clr_start = 1;
            tick();
            clr_start = 0;
            done_seen |= a_done | b_done;
        end
        chk("mid_pre_q0", a_q0, 32'hFFFFFFFF);
        chk("mid_pre_busy", a_busy, 1);
        reset_n = 0;
        #1;
        chk("mid_rst_a", {a_q0, a_q1}, 0);
        chk("mid_rst_b", {b_q0, b_q1}, 0);
        chk("mid_rst_flags", {a_busy, a_done, a_rv0, b_busy, b_rv0}, 0);
        tick(); tick();
        reset_n = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            done_seen |= a_done | b_done;
        end
        chk("mid_no_done", done_seen, 0);
        check_mem("mid_mem", 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dp_bram_clr.md
DP_BRAM_CLR -- requirements
Module: dp_bram_clr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: address width, equal to log2(MEM_DEPTH).
REQ-002 SHALL have parameter MEM_DEPTH, default 512: number of words, 2..2^ADDR_WIDTH.
REQ-003 SHALL have parameter COL_WIDTH, default 8: bits per write-enable column.
REQ-004 SHALL have parameter NUM_COL, default 4: columns per word; MEM_WIDTH = COL_WIDTH*NUM_COL.
REQ-005 SHALL have parameter READ_LATENCY, default 1: 1 or 2 cycles from ce to q.
REQ-006 SHALL have parameter WRITE_MODE, default 0: 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-007 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports addr0/addr1  input  ADDR_WIDTH  word address for port 0/1.
REQ-010 SHALL have ports ce0/ce1  input  1  port enable.
REQ-011 SHALL have ports we0/we1  input  NUM_COL  per-column write enable, qualified by ce.
REQ-012 SHALL have ports d0/d1  input  MEM_WIDTH  write data.
REQ-013 SHALL have ports q0/q1  output  MEM_WIDTH  registered read data.
REQ-014 SHALL have ports rvalid0/rvalid1  output  1  q valid strobe, one cycle per accepted access.
REQ-015 SHALL have port clr_start  input  1  request to clear whole memory to zero.
REQ-016 SHALL have port clr_busy  output  1  clear engine active; user accesses blocked.
REQ-017 SHALL have port clr_done  output  1  one-cycle pulse at clear completion.
REQ-018 SHALL have port collision  output  1  one-cycle pulse flagging a same-address conflict.

Function
REQ-019 SHALL accept a port access when ceN=1 and clr_busy=0; with clr_busy=1 ceN is ignored (no write, no rvalid).
REQ-020 SHALL write column i of the word at addrN from dN[i*COL_WIDTH +: COL_WIDTH] when weN[i]=1; other columns are unchanged.
REQ-021 SHALL present q/rvalid READ_LATENCY cycles after an accepted access; q holds its last value when no access completes.
REQ-022 SHALL, with WRITE_MODE=0, return the pre-write word on q; with WRITE_MODE=1, return the word after the column merge.
REQ-023 SHALL, when both ports access the same address in one cycle and at least one writes: pulse collision 1 cycle later; for overlapping columns written by both ports, port 1 data wins.
REQ-024 SHALL, in a collision, return the pre-write stored word on a port that only reads (independent of WRITE_MODE); a writing port follows REQ-022 using the final merged word.
REQ-025 SHALL implement clear FSM IDLE -> CLEAR -> DONE -> IDLE.
REQ-026 SHALL move IDLE->CLEAR on clr_start=1; the user access presented in that same cycle is still performed.
REQ-027 SHALL in CLEAR write all-zero words to addresses 0..MEM_DEPTH-1, one per cycle, ascending; clr_busy=1 throughout.
REQ-028 SHALL move CLEAR->DONE after address MEM_DEPTH-1 is written, then DONE->IDLE unconditionally; clr_done=1 only in DONE, clr_busy=0 in DONE.
REQ-029 SHALL ignore clr_start while in CLEAR or DONE.
REQ-030 SHALL complete in-flight reads (READ_LATENCY pipeline) normally after clear begins.

Reset
REQ-031 SHALL on reset_n=0, immediately: FSM to IDLE, clear address to 0, q0=q1=0, rvalid0=rvalid1=0, clr_busy=0, clr_done=0, collision=0, read pipeline flushed.
REQ-032 SHALL leave memory contents unchanged by reset; a clear interrupted by reset is abandoned with no clr_done.

Verification
REQ-033 Port 0 write addr 5 d=0xAABBCCDD we=1111, then write we=0010 d=0x00001100, then read -> q0=0xAABB11DD, rvalid0 after READ_LATENCY.
REQ-034 WRITE_MODE=0 and 1: write 0x11111111 over 0x22222222 at addr 3 -> q=0x22222222 (mode 0), 0x11111111 (mode 1).
REQ-035 Both ports write addr 7 same cycle, we0=1111 d0=0x01020304, we1=0011 d1=0xA0B0C0D0 -> stored 0x0102C0D0, collision pulsed once.
REQ-036 Fill memory with 0xFFFFFFFF, pulse clr_start -> clr_busy for exactly MEM_DEPTH cycles, clr_done one cycle, every address reads 0; ce during busy writes nothing.
REQ-037 Assert reset_n=0 mid-clear at address 100 -> outputs zero immediately; addresses 0..99 read 0, 100.. keep old data; no clr_done.
